// File: rtl/issue_scheduler_pkg.sv
//==============================================================================
// issue_scheduler_pkg : condition codes, FSM states and flag constants
// Rev 1.0
//==============================================================================
`default_nettype none

package issue_scheduler_pkg;

    localparam logic [2:0] PEND_MAX = 3'd7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EVAL       = 2'd1,
        ST_WAIT_FLAGS = 2'd2,
        ST_ISSUE      = 2'd3
    } state_t;

    // Data-processing instruction with the S bit set
    function automatic logic is_flag_setter(input logic [31:0] word);
        return (word[27:26] == 2'b00) && word[20];
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_scheduler_if.sv
//==============================================================================
// issue_scheduler_if : fetch-side and decode-side handshakes of the scheduler
// Rev 1.0
//==============================================================================
`default_nettype none

interface issue_scheduler_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/issue_scheduler_cond_check.sv
//==============================================================================
// issue_scheduler_cond_check : ARM condition-code evaluation against N,Z,C,V
// Rev 1.0
//==============================================================================
`default_nettype none

module issue_scheduler_cond_check
    import issue_scheduler_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cpsr_flags,
    output logic       pass
);
    logic w_n, w_z, w_c, w_v;

    assign w_n = cpsr_flags[FLAG_N];
    assign w_z = cpsr_flags[FLAG_Z];
    assign w_c = cpsr_flags[FLAG_C];
    assign w_v = cpsr_flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = !w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = !w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = !w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = !w_v;
            COND_HI: pass = w_c && !w_z;
            COND_LS: pass = !w_c || w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = !w_z && (w_n == w_v);
            COND_LE: pass = w_z || (w_n != w_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/issue_scheduler.sv
//==============================================================================
// issue_scheduler : single-entry hold that issues conditional instructions once
//                   in-flight flag writers have retired. Rev 1.0
//==============================================================================
`default_nettype none

module issue_scheduler
    import issue_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    issue_scheduler_if.slave    bus,
    input  logic [3:0]          cpsr_flags,
    input  logic                flag_done,
    input  logic                flush,
    output logic [2:0]          pending,
    output logic [15:0]         squash_count
);
    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hold;
    logic [31:0] r_last;
    logic [2:0]  r_pending;
    logic [15:0] r_squash;

    logic w_pass, w_setter, w_stall, w_is_al;
    logic w_in_xfer, w_out_xfer, w_eval_fail, w_inc, w_dec;

    issue_scheduler_cond_check u_cond_check (
        .cond       (r_hold[31:28]),
        .cpsr_flags (cpsr_flags),
        .pass       (w_pass)
    );

    assign w_setter    = is_flag_setter(r_hold);
    assign w_stall     = w_setter && (r_pending == PEND_MAX);
    assign w_is_al     = (r_hold[31:28] == COND_AL);
    assign w_in_xfer   = bus.in_valid && bus.in_ready;
    assign w_out_xfer  = bus.out_valid && bus.out_ready;
    // Flags are only trusted when no writer is in flight
    assign w_eval_fail = (r_state == ST_EVAL) && !w_is_al && (r_pending == 3'd0) && !w_pass;
    assign w_inc       = w_out_xfer && w_setter;
    assign w_dec       = flag_done && (r_pending != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) w_next = ST_EVAL;
                end
                ST_EVAL: begin
                    if (w_is_al || ((r_pending == 3'd0) && w_pass)) w_next = ST_ISSUE;
                    else if (r_pending != 3'd0)                    w_next = ST_WAIT_FLAGS;
                    else                                           w_next = ST_IDLE;
                end
                ST_WAIT_FLAGS: begin
                    if (r_pending == 3'd0) w_next = ST_EVAL;
                end
                ST_ISSUE: begin
                    if (w_out_xfer) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE) && !reset;
        bus.out_valid = (r_state == ST_ISSUE) && !w_stall;
        bus.out_data  = (r_state == ST_ISSUE) ? r_hold : r_last;
    end

    // An out transfer coinciding with flush still retires the word and counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold    <= '0;
            r_last    <= '0;
            r_pending <= '0;
            r_squash  <= '0;
        end else begin
            if (w_out_xfer) r_last <= r_hold;
            if (flush || w_eval_fail) begin
                r_hold <= '0;
            end else if (w_in_xfer) begin
                r_hold <= bus.in_data;
            end
            if (w_eval_fail && !flush) r_squash <= r_squash + 16'd1;
            r_pending <= r_pending + {2'b00, w_inc} - {2'b00, w_dec};
        end
    end

    assign pending      = r_pending;
    assign squash_count = r_squash;
endmodule

`default_nettype wire

// File: tb/tb_issue_scheduler.sv
//==============================================================================
// tb_issue_scheduler : directed vectors plus a per-cycle reference model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_issue_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cpsr_flags = 4'b0000;
    logic        flag_done = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  pending;
    logic [15:0] squash_count;

    int n_vec = 0;
    int n_err = 0;

    issue_scheduler_if bus();

    issue_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .cpsr_flags   (cpsr_flags),
        .flag_done    (flag_done),
        .flush        (flush),
        .pending      (pending),
        .squash_count (squash_count)
    );

    always #5 clk = ~clk;

    // Reference model: one instruction slot with a decision time stamp
    bit          m_slot, m_offered, m_waiting;
    logic [31:0] m_word, m_last;
    int          m_decide_at, m_cyc, m_pend;
    logic [15:0] m_squash;
    bit          t_ov, t_took, t_inc, t_dec;
    int          t_p0;
    logic [3:0]  t_cond;

    function automatic bit ref_setter(input logic [31:0] w);
        return (w[27:26] == 2'b00) && (w[20] == 1'b1);
    endfunction

    // ARM conditions come in complementary pairs: bit 0 inverts the base test
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic bit ref_out_valid();
        return m_slot && m_offered && !(ref_setter(m_word) && m_pend == 7);
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_slot = 0; m_offered = 0; m_waiting = 0;
            m_word = '0; m_last = '0; m_pend = 0; m_squash = '0;
            m_decide_at = 0; m_cyc = 0;
        end else begin
            t_ov   = ref_out_valid();
            t_p0   = m_pend;
            t_took = t_ov && bus.out_ready;
            t_inc  = t_took && ref_setter(m_word);
            t_dec  = flag_done && (t_p0 != 0);
            if (t_took) m_last = m_word;
            if (flush) begin
                m_slot = 0; m_offered = 0; m_waiting = 0;
            end else if (!m_slot) begin
                if (bus.in_valid) begin
                    m_slot = 1; m_offered = 0; m_waiting = 0;
                    m_word = bus.in_data; m_decide_at = m_cyc + 1;
                end
            end else if (m_offered) begin
                if (t_took) begin m_slot = 0; m_offered = 0; end
            end else if (m_waiting) begin
                if (t_p0 == 0) begin m_waiting = 0; m_decide_at = m_cyc + 1; end
            end else if (m_cyc >= m_decide_at) begin
                if (m_word[31:28] == 4'hE)                  m_offered = 1;
                else if (t_p0 != 0)                         m_waiting = 1;
                else if (ref_cond(m_word[31:28], cpsr_flags)) m_offered = 1;
                else begin m_squash = m_squash + 16'd1; m_slot = 0; end
            end
            m_pend = t_p0 + int'(t_inc) - int'(t_dec);
            m_cyc  = m_cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_in_ready",  {31'b0, bus.in_ready},  {31'b0, (!reset && !m_slot)});
        chk("cmp_out_valid", {31'b0, bus.out_valid}, {31'b0, ref_out_valid()});
        chk("cmp_out_data",  bus.out_data, (m_slot && m_offered) ? m_word : m_last);
        chk("cmp_pending",   {29'b0, pending}, m_pend);
        chk("cmp_squash",    {16'b0, squash_count}, {16'b0, m_squash});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (bus.in_ready) seen = 1;
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    logic [3:0] pats [3] = '{4'b0010, 4'b1001, 4'b0110};

    initial begin
        bit seen;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'd0);
        chk("rst_out_data",  bus.out_data, 32'd0);
        chk("rst_pending",   {29'b0, pending}, 32'd0);
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // EQ with Z set: issued two cycles after acceptance
        cpsr_flags = 4'b0100;
        send(32'h0A000001);
        @(negedge clk);
        chk("eq_n1_out_valid", {31'b0, bus.out_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("eq_n2_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("eq_n2_out_data",  bus.out_data, 32'h0A000001);
        chk("eq_squash",       {16'b0, squash_count}, 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // EQ with Z clear: squashed, fetch side ready again at N+2
        cpsr_flags = 4'b0000;
        send(32'h0A000001);
        step();
        @(negedge clk);
        chk("ne_fail_in_ready",  {31'b0, bus.in_ready}, 32'd1);
        chk("ne_fail_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ne_fail_squash",    {16'b0, squash_count}, 32'd1);

        // Every condition under three flag patterns; each pattern fails 8 of 16
        bus.out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            cpsr_flags = pats[p];
            for (int c = 0; c < 16; c++) begin
                t_cond = c[3:0];
                send({t_cond, 28'h0A00000});
                wait_idle("sweep_idle");
            end
        end
        chk("sweep_squash",       {16'b0, squash_count}, 32'd25);
        chk("model_sweep_squash", {16'b0, m_squash}, 32'd25);

        // SUBS in flight holds a following NE until its flags retire
        cpsr_flags = 4'b0000;
        send(32'hE0500001);
        wait_idle("subs_idle");
        chk("subs_pending", {29'b0, pending}, 32'd1);
        send(32'h1A000002);
        repeat (4) step();
        @(negedge clk);
        chk("ne_wait_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ne_wait_pending",   {29'b0, pending}, 32'd1);
        flag_done = 1'b1;
        step();
        flag_done = 1'b0;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
                chk("ne_issue_data", bus.out_data, 32'h1A000002);
            end
        end
        chk("ne_issued", {31'b0, seen}, 32'd1);
        wait_idle("ne_idle");
        chk("ne_pending", {29'b0, pending}, 32'd0);

        // Seven flag setters saturate the counter; the eighth stalls
        for (int i = 0; i < 7; i++) begin
            send(32'hE0500001);
            wait_idle("setter_idle");
        end
        chk("sat_pending",       {29'b0, pending}, 32'd7);
        chk("model_sat_pending", m_pend, 32'd7);
        bus.out_ready = 1'b0;
        send(32'hE0500001);
        repeat (3) step();
        @(negedge clk);
        chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("stall_pending",   {29'b0, pending}, 32'd7);
        flag_done = 1'b1;
        step();
        flag_done = 1'b0;
        @(negedge clk);
        chk("unstall_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("unstall_pending",   {29'b0, pending}, 32'd6);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("issued8_pending",  {29'b0, pending}, 32'd7);
        chk("issued8_in_ready", {31'b0, bus.in_ready}, 32'd1);
        flag_done = 1'b1;
        repeat (7) step();
        flag_done = 1'b0;
        @(negedge clk);
        chk("drain_pending", {29'b0, pending}, 32'd0);

        // Flush of a held MOV with one writer in flight
        bus.out_ready = 1'b1;
        send(32'hE0500001);
        wait_idle("pre_flush_idle");
        bus.out_ready = 1'b0;
        send(32'hE3A00001);
        step();
        @(negedge clk);
        chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_out_data",  bus.out_data, 32'hE3A00001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_out_data",  bus.out_data, 32'hE0500001);
        chk("flush_pending",   {29'b0, pending}, 32'd1);
        chk("flush_squash",    {16'b0, squash_count}, 32'd25);

        // Flush on the same edge as an out transfer: the transfer still counts
        send(32'hE0500001);
        step();
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        bus.out_ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flushxfer_pending",   {29'b0, pending}, 32'd2);
        chk("flushxfer_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flushxfer_out_data",  bus.out_data, 32'hE0500001);

        // Reset while evaluating
        send(32'h0A000001);
        reset = 1'b1;
        #2;
        chk("midrst_in_ready",  {31'b0, bus.in_ready}, 32'd0);
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_out_data",  bus.out_data, 32'd0);
        chk("midrst_pending",   {29'b0, pending}, 32'd0);
        chk("midrst_squash",    {16'b0, squash_count}, 32'd0);
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_release_in_ready", {31'b0, bus.in_ready}, 32'd1);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 PEND_MAX, 7, maximum number of flag-setting instructions in flight past the scheduler.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  fetch side: instruction word valid.
REQ-005 in_data  input  32  fetch side: instruction word.
REQ-006 in_ready  output  1  fetch side: scheduler accepts a word this cycle.
REQ-007 out_valid  output  1  decode side: issued instruction valid.
REQ-008 out_data  output  32  decode side: issued instruction word.
REQ-009 out_ready  input  1  decode side: decode accepts the word this cycle.
REQ-010 cpsr_flags  input  4  regbank flags, bits [3:0] = N,Z,C,V.
REQ-011 flag_done  input  1  one-cycle pulse: one in-flight flag-setting instruction has written the CPSR.
REQ-012 flush  input  1  one-cycle pulse: discard the held instruction.
REQ-013 pending  output  3  count of issued flag-setting instructions not yet retired.
REQ-014 squash_count  output  16  count of instructions dropped on condition fail; wraps at 16'hFFFF -> 0.

Function
REQ-015 A transfer occurs on in_valid && in_ready, or on out_valid && out_ready.
REQ-016 States: IDLE, EVAL, WAIT_FLAGS, ISSUE; single-entry holding register (hold).
REQ-017 IDLE: in_ready = 1; on transfer, latch in_data into hold, go to EVAL.
REQ-018 EVAL: cond = hold[31:28]; cond 1110 -> ISSUE; otherwise pending != 0 -> WAIT_FLAGS; otherwise evaluate cond against cpsr_flags sampled this cycle.
REQ-019 Cond evaluation follows ARM EQ..LE (0000-1101) exactly; 1111 always fails.
REQ-020 Pass -> ISSUE; fail -> squash_count increments, hold discarded, go to IDLE.
REQ-021 WAIT_FLAGS: go to EVAL in the cycle after pending is observed as 0.
REQ-022 Flag-setter: hold[27:26] == 00 and hold[20] == 1.
REQ-023 ISSUE: out_data = hold; out_valid = 1 unless hold is a flag-setter and pending == PEND_MAX (stall, out_valid = 0).
REQ-024 On an out transfer: flag-setter -> pending increments; go to IDLE.
REQ-025 out_valid and out_data hold stable until transfer; out_data is don't-care-free, holding the last issued word.
REQ-026 flag_done decrements pending; flag_done at pending == 0 is ignored.
REQ-027 Increment and flag_done in the same cycle -> pending unchanged.
REQ-028 Latency: cond 1110 accepted in cycle N -> out_valid in cycle N+2; conditional with pending == 0 -> N+2; fail -> in_ready again in N+2.
REQ-029 in_ready = 0 in every state except IDLE; there is no accept/issue overlap.
REQ-030 flush has priority over all other events: any state -> IDLE, hold discarded, out_valid deasserted next cycle.
REQ-031 flush does not change pending or squash_count; in-flight writers still retire via flag_done.
REQ-032 flush coinciding with an out transfer: the transfer counts, including the pending increment.

Reset
REQ-033 reset asserted: state IDLE, hold 0, out_data 0, out_valid 0, in_ready 0, pending 0, squash_count 0.
REQ-034 Reset mid-operation discards the held instruction; in_ready rises in the first cycle after deassertion.

Structure
REQ-035 Shared package: the cond-code constants (EQ..AL, NV), the state enum, PEND_MAX, and flag bit positions.
REQ-036 One sub-module, cond_check: combinational, inputs cond and cpsr_flags, output pass.

Verification
REQ-037 cpsr_flags = 4'b0100, in_data 32'h0A000001 (EQ) -> issued at N+2, squash_count 0.
REQ-038 cpsr_flags = 4'b0000, in_data 32'h0A000001 -> not issued, squash_count = 1, in_ready high at N+2.
REQ-039 Issue 32'hE0500001 (SUBS; pending = 1), then 32'h1A000002 (NE) -> held in WAIT_FLAGS; flag_done with Z = 0 -> issued.
REQ-040 Issue 7 flag-setters without flag_done, then an 8th -> out_valid stays 0 until one flag_done, then issued with pending = 7.
REQ-041 Hold 32'hE3A00001 with out_ready = 0, pulse flush -> out_valid 0 next cycle, pending unchanged; assert reset mid-EVAL -> all outputs at reset values.
